sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 90 +++++++++
 tb/tb_sram_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM between two requesters with programmable wait states.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_port_arbiter #(
    parameter int AW   = 11,
    parameter int DW   = 16,
    parameter int WAIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          stall0,
    output logic [AW-1:0] sram_addr,
    output logic          sram_we,
    output logic          sram_re,
    inout  wire  [DW-1:0] sram_data
);
    localparam int CW = WAIT > 1 ? $clog2(WAIT) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] wdata_l;
    logic gnt, pick;
`ifdef SRAM_ARB_RR_EN
    logic last;
    assign pick = ~(req0 & (~req1 | last));
`else
    assign pick = ~req0;
`endif
    assign stall0 = req0 & ~ack0;
    // The write strobe is only ever high during a write ACCESS, so it doubles as the bus enable.
    assign sram_data = sram_we ? wdata_l : 'z;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata_l   <= '0;
            gnt       <= 1'b0;
            sram_addr <= '0;
            sram_we   <= 1'b0;
            sram_re   <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifdef SRAM_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: if (req0 | req1) begin
                    gnt       <= pick;
                    sram_addr <= pick ? addr1 : addr0;
                    wdata_l   <= pick ? wdata1 : wdata0;
                    sram_we   <= pick ? we1 : we0;
                    sram_re   <= ~(pick ? we1 : we0);
                    cnt       <= CW'(WAIT - 1);
`ifdef SRAM_ARB_RR_EN
                    last      <= pick;
`endif
                    state     <= ACCESS;
                end
                ACCESS: if (cnt == '0) begin
                    sram_we <= 1'b0;
                    sram_re <= 1'b0;
                    if (sram_re && gnt) rdata1 <= sram_data;
                    if (sram_re && !gnt) rdata0 <= sram_data;
                    ack0    <= ~gnt;
                    ack1    <= gnt;
                    state   <= RESP;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized two-port traffic against a transaction-level model,
// plus a WAIT=3 instance for multi-cycle strobe timing.
module tb_sram_port_arbiter;
    localparam int AW = 11, DW = 16, WAIT = 1, W3 = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic ack0, ack1, stall0, sram_we, sram_re;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic req3 = 1'b0;
    logic [AW-1:0] addr3 = '0, sram_addr3;
    logic ack3, ack3b, stall3, we3s, re3;
    logic [DW-1:0] rdata3, rdata3b;
    wire  [DW-1:0] sram_data3;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    logic [DW-1:0] exp_rd [2];
    logic last_g = 1'b1;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) u_dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_re(sram_re), .sram_data(sram_data)
    );

    sram_port_arbiter #(.AW(AW), .DW(DW), .WAIT(W3)) u_w3 (
        .clk(clk), .rst(rst), .req0(req3), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(addr3), .addr1('0), .wdata0('0), .wdata1('0),
        .ack0(ack3), .ack1(ack3b), .rdata0(rdata3), .rdata1(rdata3b), .stall0(stall3),
        .sram_addr(sram_addr3), .sram_we(we3s), .sram_re(re3), .sram_data(sram_data3)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] x);
        return DW'(x) ^ 16'hA5C3;
    endfunction

    assign sram_data  = sram_re ? mem[sram_addr] : 'z;
    assign sram_data3 = re3 ? pat(sram_addr3) : 'z;
    always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction per requesting port, launched together; expectations come from
    // priority order and the access timeline (strobes for WAIT cycles, then one ack cycle).
    task automatic round(input logic [1:0] who, input logic wa, input logic wb,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                         input logic [DW-1:0] da, input logic [DW-1:0] db);
        int samp [2], tack [2];
        logic act [2], w [2], first, ew, er;
        logic [AW-1:0] a [2], ea;
        logic [DW-1:0] d [2], ed;
        act[0] = who[0]; act[1] = who[1];
        w[0] = wa; w[1] = wb; a[0] = aa; a[1] = ab; d[0] = da; d[1] = db;
`ifdef SRAM_ARB_RR_EN
        first = (who == 2'b11) ? !last_g : (who[1] & !who[0]);
`else
        first = who[1] & !who[0];
`endif
        last_g = (who == 2'b11) ? !first : first;
        samp[first] = 0;
        samp[!first] = WAIT + 2;
        for (int p = 0; p < 2; p++) tack[p] = samp[p] + WAIT;
        req0 = act[0]; we0 = wa; addr0 = aa; wdata0 = da;
        req1 = act[1]; we1 = wb; addr1 = ab; wdata1 = db;
        for (int n = 0; n <= 2 * WAIT + 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            ew = 1'b0; er = 1'b0; ea = '0; ed = '0;
            for (int p = 0; p < 2; p++)
                if (act[p] && n >= samp[p] && n < tack[p]) begin
                    ew = w[p]; er = !w[p]; ea = a[p]; ed = d[p];
                end
            for (int p = 0; p < 2; p++)
                if (act[p] && n == tack[p]) begin
                    if (w[p]) ref_mem[a[p]] = d[p];
                    else exp_rd[p] = ref_mem[a[p]];
                end
            check("ack0", 32'(ack0), 32'(act[0] && n == tack[0]));
            check("ack1", 32'(ack1), 32'(act[1] && n == tack[1]));
            check("stall0", 32'(stall0), 32'(act[0] && n < tack[0]));
            check("sram_we", 32'(sram_we), 32'(ew));
            check("sram_re", 32'(sram_re), 32'(er));
            if (ew || er) check("sram_addr", 32'(sram_addr), 32'(ea));
            if (ew) check("wr_bus", 32'(sram_data), 32'(ed));
            check("rdata0", 32'(rdata0), 32'(exp_rd[0]));
            check("rdata1", 32'(rdata1), 32'(exp_rd[1]));
            if (act[0] && n == tack[0]) req0 = 1'b0;
            if (act[1] && n == tack[1]) req1 = 1'b0;
            // Granted ports wiggle addr/wdata; the latched values must be what reaches the SRAM.
            if (act[0] && n >= samp[0] && n < tack[0]) begin
                addr0 = AW'($urandom); wdata0 = DW'($urandom);
            end
            if (act[1] && n >= samp[1] && n < tack[1]) begin
                addr1 = AW'($urandom); wdata1 = DW'($urandom);
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r = $urandom_range(0, 7);
        return r == 0 ? '0 : r == 1 ? '1 : AW'($urandom);
    endfunction

    initial begin
        int k;
        logic g;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[11'h010] = 16'hBEEF;
        ref_mem[11'h010] = 16'hBEEF;
        exp_rd[0] = '0; exp_rd[1] = '0;
        #1 rst = 1'b0;
        #1;
        check("rst_ack0", 32'(ack0), 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_rdata0", 32'(rdata0), 0);
        check("rst_rdata1", 32'(rdata1), 0);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_we", 32'(sram_we), 0);
        check("rst_re", 32'(sram_re), 0);
        check("rst_stall0", 32'(stall0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        round(2'b01, 1'b0, 1'b0, 11'h010, '0, '0, '0);
        round(2'b10, 1'b0, 1'b1, '0, 11'h7FF, '0, 16'h1234);
        round(2'b10, 1'b0, 1'b0, '0, 11'h7FF, '0, '0);
        round(2'b11, 1'b0, 1'b1, 11'h000, 11'h7FF, '0, 16'hA5A5);
        round(2'b11, 1'b1, 1'b0, 11'h000, 11'h000, 16'h5A5A, '0);
        for (int r = 0; r < 40; r++)
            round(2'($urandom_range(1, 3)), 1'($urandom), 1'($urandom),
                  rand_addr(), rand_addr(), DW'($urandom), DW'($urandom));
        // Both requests held across acks: each return to IDLE is a fresh tie.
        addr0 = rand_addr(); addr1 = rand_addr(); we0 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        k = 0;
        for (int n = 0; n < 8 * (WAIT + 2) && k < 4; n++) begin
            @(negedge clk);
            check("one_ack", 32'(ack0 & ack1), 0);
            if (ack0 | ack1) begin
`ifdef SRAM_ARB_RR_EN
                g = !last_g;
`else
                g = 1'b0;
`endif
                last_g = g;
                exp_rd[g] = ref_mem[g ? addr1 : addr0];
                check("hold_grant", 32'(ack1), 32'(g));
                check("hold_rdata", 32'(g ? rdata1 : rdata0), 32'(exp_rd[g]));
                k++;
            end
        end
        check("hold_count", k, 4);
        req0 = 1'b0; req1 = 1'b0;
        repeat (WAIT + 3) @(negedge clk);
        // Reset in the middle of a write access.
        we0 = 1'b1; addr0 = 11'h155; wdata0 = 16'hC0DE; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_we", 32'(sram_we), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(sram_we), 0);
        check("mid_rst_re", 32'(sram_re), 0);
        check("mid_rst_addr", 32'(sram_addr), 0);
        check("mid_rst_rdata0", 32'(rdata0), 0);
        check("mid_rst_rdata1", 32'(rdata1), 0);
        check("mid_rst_stall0", 32'(stall0), 1);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0; last_g = 1'b1;
        repeat (WAIT + 3) begin
            @(negedge clk);
            check("no_ack_after_rst", 32'(ack0 | ack1), 0);
        end
        round(2'b01, 1'b1, 1'b0, 11'h155, '0, 16'hC0DE, '0);
        round(2'b01, 1'b0, 1'b0, 11'h155, '0, '0, '0);
        round(2'b11, 1'b0, 1'b0, 11'h155, 11'h010, '0, '0);
        // WAIT=3 instance: read strobe held three cycles, ack on the fourth.
        for (int r = 0; r < 3; r++) begin
            addr3 = rand_addr(); req3 = 1'b1;
            for (int n = 0; n <= W3 + 2; n++) begin
                @(posedge clk);
                @(negedge clk);
                check("w3_re", 32'(re3), 32'(n < W3));
                check("w3_ack", 32'(ack3), 32'(n == W3));
                if (n == W3) begin
                    check("w3_rdata", 32'(rdata3), 32'(pat(addr3)));
                    req3 = 1'b0;
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
